// File: rtl/mc_control_unit.sv
// Multi-cycle control sequencer for the MIPS-subset core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over a single shared,
// variable-latency memory port. Traps on illegal opcodes or memory timeout and
// counts retired instructions. aluc/pcsrc encodings match the single-cycle core.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   op, func            opcode / function field from the instruction register
//   z                   ALU zero flag, meaningful in EXEC
//   mem_ready           memory completes the current access this cycle
//   memread, iord       memory read strobe; address select (0=PC, 1=ALU result)
//   irwrite, pcwrite    instruction register load; PC load
//   wmem, wreg, mem2reg, regrt, jal, shift, aluimm, s_ext, aluc, pcsrc
//                       datapath controls, same meaning as the single-cycle core
//   trap                high while in TRAP
//   illegal, timeout    sticky trap causes, cleared only by reset
//   instr_count         retired-instruction count (wraps)
//   state               current state, for debug
module mc_control_unit #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             z,
  input  logic             mem_ready,
  output logic             memread,
  output logic             iord,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             wmem,
  output logic             wreg,
  output logic             mem2reg,
  output logic             regrt,
  output logic             jal,
  output logic             shift,
  output logic             aluimm,
  output logic             s_ext,
  output logic [3:0]       aluc,
  output logic [1:0]       pcsrc,
  output logic             trap,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state
);

  localparam int unsigned WaitW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StInit   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  // Instruction decode
  logic r_type;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
  logic i_shift, i_imm_alu, legal, mem_wait_expired;

  assign r_type = (op == 6'b000000);
  assign i_add  = r_type && (func == 6'b100000);
  assign i_sub  = r_type && (func == 6'b100010);
  assign i_and  = r_type && (func == 6'b100100);
  assign i_or   = r_type && (func == 6'b100101);
  assign i_xor  = r_type && (func == 6'b100110);
  assign i_sll  = r_type && (func == 6'b000000);
  assign i_srl  = r_type && (func == 6'b000010);
  assign i_sra  = r_type && (func == 6'b000011);
  assign i_jr   = r_type && (func == 6'b001000);
  assign i_addi = (op == 6'b001000);
  assign i_andi = (op == 6'b001100);
  assign i_ori  = (op == 6'b001101);
  assign i_xori = (op == 6'b001110);
  assign i_lw   = (op == 6'b100011);
  assign i_sw   = (op == 6'b101011);
  assign i_beq  = (op == 6'b000100);
  assign i_bne  = (op == 6'b000101);
  assign i_lui  = (op == 6'b001111);
  assign i_j    = (op == 6'b000010);
  assign i_jal  = (op == 6'b000011);

  assign i_shift   = i_sll | i_srl | i_sra;
  // Immediate ALU ops that write rt in WB
  assign i_imm_alu = i_addi | i_andi | i_ori | i_xori | i_lui;

  assign legal = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra | i_jr |
                 i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_beq | i_bne |
                 i_lui | i_j | i_jal;

  assign mem_wait_expired = (wait_q == WaitW'(MEM_TIMEOUT));

  always_comb begin
    memread   = 1'b0;
    iord      = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    wmem      = 1'b0;
    wreg      = 1'b0;
    mem2reg   = 1'b0;
    regrt     = 1'b0;
    jal       = 1'b0;
    shift     = 1'b0;
    aluimm    = 1'b0;
    s_ext     = 1'b0;
    aluc      = 4'b0000;
    pcsrc     = 2'b00;
    trap      = 1'b0;
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;

    case (state_q)
      StInit: state_d = StFetch;

      StFetch: begin
        memread = 1'b1;
        iord    = 1'b0;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          pcsrc   = 2'b00;
          state_d = StDecode;
        end else if (mem_wait_expired) begin
          state_d   = StTrap;
          timeout_d = 1'b1;
        end
      end

      StDecode: begin
        if (legal) begin
          state_d = StExec;
        end else begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end
      end

      StExec: begin
        shift  = i_shift;
        aluimm = i_imm_alu | i_lw | i_sw;
        s_ext  = i_addi | i_lw | i_sw | i_beq | i_bne;
        if (i_sub || i_bne)                  aluc = 4'b0100;
        else if (i_and || i_andi)            aluc = 4'b0001;
        else if (i_or || i_ori)              aluc = 4'b0101;
        else if (i_xor || i_xori || i_beq)   aluc = 4'b0010;
        else if (i_sll)                      aluc = 4'b0011;
        else if (i_srl)                      aluc = 4'b0111;
        else if (i_sra)                      aluc = 4'b1111;
        else if (i_lui)                      aluc = 4'b0110;
        else                                 aluc = 4'b0000;

        if (i_beq) begin
          pcsrc   = 2'b01;
          pcwrite = z;
          state_d = StFetch;
        end else if (i_bne) begin
          pcsrc   = 2'b01;
          pcwrite = ~z;
          state_d = StFetch;
        end else if (i_j || i_jal) begin
          pcsrc   = 2'b11;
          pcwrite = 1'b1;
          wreg    = i_jal;
          jal     = i_jal;
          state_d = StFetch;
        end else if (i_jr) begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
          state_d = StFetch;
        end else if (i_lw || i_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end

      StMem: begin
        // Address = base + sign-extended offset, held for the whole access
        iord    = 1'b1;
        aluimm  = 1'b1;
        s_ext   = 1'b1;
        aluc    = 4'b0000;
        memread = i_lw;
        wmem    = i_sw;
        if (mem_ready) begin
          state_d = i_lw ? StWb : StFetch;
        end else if (mem_wait_expired) begin
          state_d   = StTrap;
          timeout_d = 1'b1;
        end
      end

      StWb: begin
        wreg    = 1'b1;
        regrt   = i_imm_alu | i_lw;
        mem2reg = i_lw;
        state_d = StFetch;
      end

      StTrap: trap = 1'b1;

      default: state_d = StInit;
    endcase
  end

  // Wait counter only advances while parked in FETCH/MEM; any other transition clears it.
  always_comb begin
    wait_d = '0;
    if ((state_q == StFetch || state_q == StMem) && state_d == state_q) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    if (state_d == StFetch && (state_q == StExec || state_q == StMem || state_q == StWb)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StInit;
      wait_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign instr_count = count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit. Each instruction is expanded into its
// expected per-cycle trace from a mnemonic table; one process compares every cycle.
module tb_mc_control_unit;

  localparam int unsigned CNT_W       = 32;
  localparam int unsigned MEM_TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [5:0]       op = '0;
  logic [5:0]       func = '0;
  logic             z = 1'b0;
  logic             mem_ready = 1'b0;
  logic             memread, iord, irwrite, pcwrite, wmem, wreg, mem2reg, regrt, jal;
  logic             shift, aluimm, s_ext, trap, illegal, timeout;
  logic [3:0]       aluc;
  logic [1:0]       pcsrc;
  logic [CNT_W-1:0] instr_count;
  logic [2:0]       state;

  always #5 clk = ~clk;

  mc_control_unit #(
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .func        (func),
    .z           (z),
    .mem_ready   (mem_ready),
    .memread     (memread),
    .iord        (iord),
    .irwrite     (irwrite),
    .pcwrite     (pcwrite),
    .wmem        (wmem),
    .wreg        (wreg),
    .mem2reg     (mem2reg),
    .regrt       (regrt),
    .jal         (jal),
    .shift       (shift),
    .aluimm      (aluimm),
    .s_ext       (s_ext),
    .aluc        (aluc),
    .pcsrc       (pcsrc),
    .trap        (trap),
    .illegal     (illegal),
    .timeout     (timeout),
    .instr_count (instr_count),
    .state       (state)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        memread, iord, irwrite, pcwrite, wmem, wreg, mem2reg, regrt, jal;
    logic        shift, aluimm, sext;
    logic [3:0]  aluc;
    logic [1:0]  pcsrc;
    logic        trap, illegal, timeout;
    logic [31:0] count;
  } obs_t;

  typedef enum int {KAlu, KLw, KSw, KBeq, KBne, KJ, KJal, KJr} kind_e;

  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    logic [3:0] aluc;
    logic       shift, aluimm, sext, regrt;
    kind_e      kind;
  } info_t;

  obs_t  dut_obs;
  assign dut_obs = {state, memread, iord, irwrite, pcwrite, wmem, wreg, mem2reg, regrt, jal,
                    shift, aluimm, s_ext, aluc, pcsrc, trap, illegal, timeout, instr_count};

  int    n_tests = 0;
  int    n_fail = 0;
  obs_t  exp_obs;
  string exp_name = "";
  bit    exp_valid = 1'b0;

  // Architectural model state
  logic        m_illegal = 1'b0;
  logic        m_timeout = 1'b0;
  logic [31:0] m_count = '0;

  function automatic info_t row(input logic [5:0] o, input logic [5:0] f, input logic [3:0] a,
                                input logic sh, input logic im, input logic se,
                                input logic rt, input kind_e k);
    info_t r;
    r.op = o; r.func = f; r.aluc = a; r.shift = sh; r.aluimm = im; r.sext = se;
    r.regrt = rt; r.kind = k;
    return r;
  endfunction

  // Mnemonic table; I-type entries carry func=111111 so a decoder looking at func would trip.
  function automatic info_t info(input int idx);
    case (idx)
      0:  return row(6'b000000, 6'b100000, 4'b0000, 0, 0, 0, 0, KAlu); // ADD
      1:  return row(6'b000000, 6'b100010, 4'b0100, 0, 0, 0, 0, KAlu); // SUB
      2:  return row(6'b000000, 6'b100100, 4'b0001, 0, 0, 0, 0, KAlu); // AND
      3:  return row(6'b000000, 6'b100101, 4'b0101, 0, 0, 0, 0, KAlu); // OR
      4:  return row(6'b000000, 6'b100110, 4'b0010, 0, 0, 0, 0, KAlu); // XOR
      5:  return row(6'b000000, 6'b000000, 4'b0011, 1, 0, 0, 0, KAlu); // SLL
      6:  return row(6'b000000, 6'b000010, 4'b0111, 1, 0, 0, 0, KAlu); // SRL
      7:  return row(6'b000000, 6'b000011, 4'b1111, 1, 0, 0, 0, KAlu); // SRA
      8:  return row(6'b000000, 6'b001000, 4'b0000, 0, 0, 0, 0, KJr);  // JR
      9:  return row(6'b001000, 6'b111111, 4'b0000, 0, 1, 1, 1, KAlu); // ADDI
      10: return row(6'b001100, 6'b111111, 4'b0001, 0, 1, 0, 1, KAlu); // ANDI
      11: return row(6'b001101, 6'b111111, 4'b0101, 0, 1, 0, 1, KAlu); // ORI
      12: return row(6'b001110, 6'b111111, 4'b0010, 0, 1, 0, 1, KAlu); // XORI
      13: return row(6'b100011, 6'b111111, 4'b0000, 0, 1, 1, 1, KLw);  // LW
      14: return row(6'b101011, 6'b111111, 4'b0000, 0, 1, 1, 0, KSw);  // SW
      15: return row(6'b000100, 6'b111111, 4'b0010, 0, 0, 1, 0, KBeq); // BEQ
      16: return row(6'b000101, 6'b111111, 4'b0100, 0, 0, 1, 0, KBne); // BNE
      17: return row(6'b001111, 6'b111111, 4'b0110, 0, 1, 0, 1, KAlu); // LUI
      18: return row(6'b000010, 6'b111111, 4'b0000, 0, 0, 0, 0, KJ);   // J
      default: return row(6'b000011, 6'b111111, 4'b0000, 0, 0, 0, 0, KJal); // JAL
    endcase
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t e;
    e = '0;
    e.st = st;
    e.illegal = m_illegal;
    e.timeout = m_timeout;
    e.count = m_count;
    return e;
  endfunction

  // Single compare process: every negedge while an expectation is armed.
  always @(negedge clk) begin
    if (exp_valid) begin
      n_tests++;
      if (dut_obs !== exp_obs) begin
        n_fail++;
        $display("FAIL cycle %s t=%0t: got %h want %h", exp_name, $time, dut_obs, exp_obs);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic cyc(input obs_t e, input string nm);
    exp_obs = e;
    exp_name = nm;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int fw, input string nm);
    obs_t e;
    for (int k = 0; k < fw; k++) begin
      mem_ready = 1'b0;
      e = base(3'd1); e.memread = 1'b1;
      cyc(e, {nm, "_fetchwait"});
    end
    mem_ready = 1'b1;
    e = base(3'd1); e.memread = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
    cyc(e, {nm, "_fetch"});
  endtask

  task automatic do_exec(input info_t i, input logic zz, input string nm);
    obs_t e;
    z = zz;
    e = base(3'd3);
    e.aluc = i.aluc; e.shift = i.shift; e.aluimm = i.aluimm; e.sext = i.sext;
    case (i.kind)
      KBeq: begin e.pcsrc = 2'b01; e.pcwrite = zz; end
      KBne: begin e.pcsrc = 2'b01; e.pcwrite = ~zz; end
      KJ:   begin e.pcsrc = 2'b11; e.pcwrite = 1'b1; end
      KJal: begin e.pcsrc = 2'b11; e.pcwrite = 1'b1; e.wreg = 1'b1; e.jal = 1'b1; end
      KJr:  begin e.pcsrc = 2'b10; e.pcwrite = 1'b1; end
      default: ;
    endcase
    cyc(e, {nm, "_exec"});
  endtask

  function automatic obs_t mem_exp(input info_t i);
    obs_t e;
    e = base(3'd4);
    e.iord = 1'b1; e.aluimm = 1'b1; e.sext = 1'b1;
    e.memread = (i.kind == KLw);
    e.wmem = (i.kind == KSw);
    return e;
  endfunction

  task automatic run(input int idx, input logic zz, input int fw, input int mw);
    info_t i;
    obs_t  e;
    string nm;
    i = info(idx);
    nm = $sformatf("i%0d", idx);
    op = i.op;
    func = i.func;
    do_fetch(fw, nm);
    cyc(base(3'd2), {nm, "_decode"});
    do_exec(i, zz, nm);
    if (i.kind == KLw || i.kind == KSw) begin
      for (int k = 0; k < mw; k++) begin
        mem_ready = 1'b0;
        cyc(mem_exp(i), {nm, "_memwait"});
      end
      mem_ready = 1'b1;
      cyc(mem_exp(i), {nm, "_mem"});
    end
    if (i.kind == KAlu || i.kind == KLw) begin
      e = base(3'd5); e.wreg = 1'b1; e.regrt = i.regrt; e.mem2reg = (i.kind == KLw);
      cyc(e, {nm, "_wb"});
    end
    m_count = m_count + 32'd1;
  endtask

  // Assert reset now (possibly mid-cycle), check the immediate effect, then release.
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    exp_valid = 1'b0;
    #1;
    chk({nm, "_obs"}, 64'(dut_obs), 64'h0);
    m_illegal = 1'b0;
    m_timeout = 1'b0;
    m_count = '0;
    @(posedge clk);
    #1;
    cyc(base(3'd0), {nm, "_held"});
    rst_n = 1'b1;
    cyc(base(3'd0), {nm, "_init"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    info_t i_sw;
    #2;
    do_reset("reset");

    // Tied-ready sequence: ADD, LW, SW, BEQ(z=1), J
    run(0, 1'b0, 0, 0);
    run(13, 1'b0, 0, 0);
    run(14, 1'b0, 0, 0);
    run(15, 1'b1, 0, 0);
    run(18, 1'b0, 0, 0);
    chk("count_after5", 64'(instr_count), 64'd5);
    chk("state_after5", 64'(state), 64'd1);

    // Branches not taken / taken
    run(15, 1'b0, 0, 0);
    run(16, 1'b0, 0, 0);
    run(16, 1'b1, 0, 0);

    // Memory wait cycles, including waits right up to the timeout limit
    run(0, 1'b0, 3, 0);
    run(13, 1'b0, 0, 2);
    run(14, 1'b0, 0, 1);
    run(13, 1'b0, 0, 15);
    run(0, 1'b0, 15, 0);

    for (int k = 1; k < 20; k++) run(k, 1'(k % 2), 0, k % 3);
    chk("count_after_all", 64'(instr_count), 64'd32);

    // Illegal opcode
    op = 6'b111111;
    func = 6'b100000;
    do_fetch(0, "ill");
    cyc(base(3'd2), "ill_decode");
    m_illegal = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1'(k % 2);
      begin
        obs_t e;
        e = base(3'd6); e.trap = 1'b1;
        cyc(e, "ill_trap");
      end
    end
    chk("ill_state", 64'(state), 64'd6);
    chk("ill_flags", 64'({trap, illegal, timeout}), 64'b110);
    chk("ill_count", 64'(instr_count), 64'd32);

    do_reset("reset2");

    // Fetch never completes: 16 FETCH cycles, then TRAP
    op = 6'b000000;
    func = 6'b100000;
    for (int k = 0; k < 16; k++) begin
      obs_t e;
      mem_ready = 1'b0;
      e = base(3'd1); e.memread = 1'b1;
      cyc(e, "to_fetch");
    end
    chk("to_state", 64'(state), 64'd6);
    m_timeout = 1'b1;
    for (int k = 0; k < 4; k++) begin
      obs_t e;
      mem_ready = 1'(k % 2);
      e = base(3'd6); e.trap = 1'b1;
      cyc(e, "to_trap");
    end
    mem_ready = 1'b1;
    #1;
    chk("to_flags", 64'({trap, illegal, timeout}), 64'b101);
    chk("to_strobes", 64'({memread, irwrite, pcwrite, wmem, wreg}), 64'd0);

    do_reset("reset3");

    // Reset asserted mid-MEM of a SW
    i_sw = info(14);
    op = i_sw.op;
    func = i_sw.func;
    do_fetch(0, "rsw");
    cyc(base(3'd2), "rsw_decode");
    do_exec(i_sw, 1'b0, "rsw");
    mem_ready = 1'b0;
    cyc(mem_exp(i_sw), "rsw_memwait");
    #2;
    chk("rsw_before", 64'({state, wmem}), 64'({3'd4, 1'b1}));
    do_reset("rsw_reset");
    chk("rsw_wmem_after", 64'(wmem), 64'd0);
    run(0, 1'b0, 0, 0);
    chk("rsw_count", 64'(instr_count), 64'd1);

    exp_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control sequencer for the MIPS-subset core; it replaces the single-cycle decoder when instruction and data share one variable-latency memory port. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB, waits on a memory ready handshake, and traps on illegal opcodes or memory timeout. It also counts retired instructions. Control encodings (aluc, pcsrc) are unchanged from the single-cycle core, so the existing ALU and PC mux are reused.

## Interface
- CNT_W, 32, width of retired-instruction counter (wraps)
- MEM_TIMEOUT, 15, max cycles to wait for mem_ready in FETCH/MEM (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  opcode from instruction register
- func  in  6  function field from instruction register
- z  in  1  ALU zero flag (valid in EXEC)
- mem_ready  in  1  memory completes current read/write this cycle
- memread, iord  out  1  memory read strobe; address select (0=PC, 1=ALU result)
- irwrite, pcwrite  out  1  instruction register load; PC load
- wmem, wreg, mem2reg, regrt, jal  out  1  as in single-cycle core
- shift, aluimm, s_ext  out  1  ALU operand controls
- aluc  out  4  ALU op
- pcsrc  out  2  00 PC+4, 01 branch, 10 register (JR), 11 jump
- trap, illegal, timeout  out  1  in TRAP state; sticky cause flags
- instr_count  out  CNT_W  retired instructions
- state  out  3  current state (debug)

## Operation
- States: INIT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. Reset → INIT; INIT → FETCH unconditionally.
- All outputs combinational from state, op, func, z, mem_ready; default 0. INIT drives all 0.
- FETCH: memread=1, iord=0. When mem_ready: irwrite=1, pcwrite=1, pcsrc=00, next DECODE.
- DECODE: legal set is R-type func {ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SLL 000000, SRL 000010, SRA 000011, JR 001000} and op {ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, LW 100011, SW 101011, BEQ 000100, BNE 000101, LUI 001111, J 000010, JAL 000011}. Illegal → TRAP with illegal set; else → EXEC.
- EXEC: aluc/shift/aluimm/s_ext as single-cycle table (ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, SLL 0011, SRL 0111, SRA 1111, LUI 0110; s_ext on ADDI/LW/SW/BEQ/BNE).
  - BEQ (aluc 0010): pcsrc=01, pcwrite=z → FETCH. BNE (aluc 0100): pcwrite=~z → FETCH.
  - J: pcsrc=11, pcwrite=1 → FETCH. JAL: also wreg=1, jal=1. JR: pcsrc=10, pcwrite=1 → FETCH.
  - LW/SW → MEM. All other legal → WB.
- MEM: iord=1, aluimm=1, s_ext=1, aluc=0000 held. LW: memread=1; on mem_ready → WB. SW: wmem=1 while waiting; on mem_ready → FETCH.
- WB: wreg=1; regrt=1 for I-type; mem2reg=1 for LW → FETCH.
- Retire: instr_count += 1 (mod 2^CNT_W) on every transition into FETCH from EXEC, MEM or WB.
- TRAP: absorbing until reset; trap=1, all strobes 0. illegal/timeout are sticky and cleared only by reset.

## Timing
- Reset values: state=INIT, instr_count=0, illegal=timeout=trap=0, wait counter=0; all control outputs 0.
- Latency with mem_ready tied 1 (FETCH→next FETCH): branch/jump 3 cycles; R/I-type ALU 4; SW 4; LW 5. Each memory wait cycle adds 1.
- Wait counter clears on entry to FETCH/MEM and increments each cycle without mem_ready. If it equals MEM_TIMEOUT and mem_ready=0 → TRAP, timeout=1. mem_ready in the same cycle wins (no trap).
- pcwrite, irwrite and wmem are never asserted in INIT, DECODE or TRAP.
- Async reset mid-instruction returns to INIT immediately; no partial write completes after rst_n falls.

## Test plan
- mem_ready=1; run ADD, LW, SW, BEQ(z=1), J. Required: state sequences 1-2-3-5, 1-2-3-4-5, 1-2-3-4, 1-2-3, 1-2-3; instr_count=5.
- BEQ with z=0, then BNE with z=0. Required: pcwrite=0 in EXEC for BEQ; pcwrite=1 with pcsrc=01 for BNE.
- FETCH with mem_ready held low for 3 cycles. Required: memread=1 throughout, irwrite pulses only on the 4th cycle, no trap.
- mem_ready never asserted, MEM_TIMEOUT=15. Required: TRAP after 16 FETCH cycles, timeout=1, trap=1, all strobes 0 thereafter.
- op=111111. Required: DECODE→TRAP, illegal=1, instr_count unchanged.
- rst_n pulsed low during MEM of SW. Required: wmem drops immediately, state=INIT, counters 0, FETCH resumes one cycle after release.
